// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and width helpers for the instruction prefetch queue.
// Pure declarations: no latency, no backpressure.
package instr_prefetch_queue_pkg;

    localparam int IPQ_INSTR_WIDTH = 14;
    localparam int IPQ_NOP_ENC     = 0;

    function automatic int ipq_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // count must represent DEPTH itself, hence one more code than the pointer
    function automatic int ipq_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side and issue-side handshake bundle of the prefetch queue.
// master drives fetch offers, flush and issue_ready; slave is the queue itself.
interface instr_prefetch_queue_if
    import instr_prefetch_queue_pkg::*;
#(
    parameter int INSTR_WIDTH = IPQ_INSTR_WIDTH,
    parameter int DEPTH       = 4
);
    logic                              fetch_valid;
    logic [INSTR_WIDTH-1:0]            fetch_instr;
    logic                              fetch_void;
    logic                              fetch_ready;
    logic                              flush;
    logic                              issue_ready;
    logic                              issue_valid;
    logic [INSTR_WIDTH-1:0]            issue_instr;
    logic                              issue_is_void;
    logic [ipq_cnt_width(DEPTH)-1:0]   count;

    modport master (
        output fetch_valid, fetch_instr, fetch_void, flush, issue_ready,
        input  fetch_ready, issue_valid, issue_instr, issue_is_void, count
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_void, flush, issue_ready,
        output fetch_ready, issue_valid, issue_instr, issue_is_void, count
    );
endinterface

// File: rtl/instr_prefetch_queue_fifo_mem_dual.sv
// DEPTH x WIDTH register array, synchronous write, combinational read; MSB is a void tag.
// clr_tag clears every void tag at the edge; data bits are never reset.
module fifo_mem_dual
    import instr_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = IPQ_INSTR_WIDTH + 1,
    parameter int DEPTH = 4,
    localparam int AW   = ipq_ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_tag,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
        if (clr_tag) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i][WIDTH-1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch FIFO between fetch and decode; a pushed word issues one cycle later.
// fetch_ready drops only when full; flush empties the queue and drops same-cycle traffic.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int                     INSTR_WIDTH = IPQ_INSTR_WIDTH,
    parameter int                     DEPTH       = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_VALUE   = INSTR_WIDTH'(IPQ_NOP_ENC)
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_queue_if.slave  bus
);
    localparam int             PW   = ipq_ptr_width(DEPTH);
    localparam int             CW   = ipq_cnt_width(DEPTH);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop;
    logic [INSTR_WIDTH:0] head;

    assign bus.fetch_ready = (count_q != FULL);
    assign bus.issue_valid = (count_q != '0);

    assign push = bus.fetch_valid & bus.fetch_ready & ~bus.flush;
    assign pop  = bus.issue_ready & bus.issue_valid & ~bus.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem_dual #(
        .WIDTH (INSTR_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .clr_tag (reset),
        .wr_en   (push & ~reset),
        .wr_addr (wr_ptr_q),
        .wr_dat  ({bus.fetch_void, bus.fetch_instr}),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head)
    );

    // Gating by occupancy keeps stale or never-written storage off the decoder.
    assign bus.issue_is_void = bus.issue_valid & head[INSTR_WIDTH];
    assign bus.issue_instr   = (bus.issue_valid && !head[INSTR_WIDTH])
                               ? head[INSTR_WIDTH-1:0] : NOP_VALUE;
    assign bus.count         = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: queue-level reference model compared every cycle,
// plus literal expectations along each scenario.
module tb_instr_prefetch_queue;
    localparam int W     = 14;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.INSTR_WIDTH(W), .DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(.INSTR_WIDTH(W), .DEPTH(DEPTH), .NOP_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of {void, word}, updated with the handshake rules.
    typedef struct {
        logic         v;
        logic [W-1:0] w;
    } ent_t;
    ent_t mq[$];
    bit   armed = 0;

    always @(posedge clk) begin
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = bus.fetch_valid && (mq.size() < DEPTH);
        do_pop  = bus.issue_ready && (mq.size() > 0);
        if (reset) begin
            mq.delete();
            armed = 1;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.v = bus.fetch_void;
                e.w = bus.fetch_instr;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_count", 32'(bus.count), 32'(mq.size()));
            chk("m_fetch_ready", 32'(bus.fetch_ready), 32'(mq.size() < DEPTH));
            chk("m_issue_valid", 32'(bus.issue_valid), 32'(mq.size() > 0));
            chk("m_issue_is_void", 32'(bus.issue_is_void), 32'(mq.size() > 0 && mq[0].v));
            chk("m_issue_instr", 32'(bus.issue_instr),
                (mq.size() == 0 || mq[0].v) ? 32'h0 : 32'(mq[0].w));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [W-1:0] fi, input logic fd,
                         input logic fl, input logic ir);
        bus.fetch_valid = fv;
        bus.fetch_instr = fi;
        bus.fetch_void  = fd;
        bus.flush       = fl;
        bus.issue_ready = ir;
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_count"}, 32'(bus.count), 32'd0);
        chk({nm, "_fetch_ready"}, 32'(bus.fetch_ready), 32'd1);
        chk({nm, "_issue_valid"}, 32'(bus.issue_valid), 32'd0);
        chk({nm, "_issue_instr"}, 32'(bus.issue_instr), 32'h0);
        chk({nm, "_issue_is_void"}, 32'(bus.issue_is_void), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        idle_chk("reset");
        tick();
        tick();
        idle_chk("idle");

        // Fill to full, overflow attempt, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, W'(14'h1001 + i), 0, 0, 0);
            tick();
        end
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_ready", 32'(bus.fetch_ready), 32'd0);
        drive(1, 14'h1005, 0, 0, 0);
        tick();
        chk("overflow_count", 32'(bus.count), 32'd4);
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_instr", 32'(bus.issue_instr), 32'h1001 + i);
            chk("drain_valid", 32'(bus.issue_valid), 32'd1);
            tick();
        end
        chk("drained_valid", 32'(bus.issue_valid), 32'd0);
        chk("drained_count", 32'(bus.count), 32'd0);

        // Streaming push and pop across pointer wraps
        drive(1, 14'h2000, 0, 0, 1);
        tick();
        for (int i = 1; i < 10; i++) begin
            chk("wrap_instr", 32'(bus.issue_instr), 32'h2000 + i - 1);
            chk("wrap_count", 32'(bus.count), 32'd1);
            drive(1, W'(14'h2000 + i), 0, 0, 1);
            tick();
        end
        chk("wrap_last", 32'(bus.issue_instr), 32'h2009);
        drive(0, '0, 0, 0, 1);
        tick();
        chk("wrap_empty", 32'(bus.count), 32'd0);

        // Voided entry issues as NOP and pops normally
        drive(1, 14'h3AAA, 1, 0, 0);
        tick();
        drive(1, 14'h3BBB, 0, 0, 0);
        tick();
        drive(0, '0, 0, 0, 0);
        chk("void_instr", 32'(bus.issue_instr), 32'h0);
        chk("void_tag", 32'(bus.issue_is_void), 32'd1);
        chk("void_valid", 32'(bus.issue_valid), 32'd1);
        drive(0, '0, 0, 0, 1);
        tick();
        chk("after_void_instr", 32'(bus.issue_instr), 32'h3BBB);
        chk("after_void_tag", 32'(bus.issue_is_void), 32'd0);
        tick();
        drive(0, '0, 0, 0, 0);
        chk("void_drained", 32'(bus.count), 32'd0);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1, W'(14'h3001 + i), 0, 0, 0);
            tick();
        end
        chk("pre_flush_count", 32'(bus.count), 32'd3);
        drive(1, 14'h3FFF, 0, 1, 1);
        tick();
        drive(0, '0, 0, 0, 1);
        idle_chk("flush");
        tick();
        chk("flush_no_3fff", 32'(bus.issue_valid), 32'd0);
        drive(0, '0, 0, 1, 0);
        tick();
        idle_chk("flush_empty");
        drive(1, 14'h0777, 0, 0, 0);
        tick();
        drive(0, '0, 0, 0, 0);
        chk("post_flush_instr", 32'(bus.issue_instr), 32'h0777);
        drive(0, '0, 0, 0, 1);
        tick();

        // Reset beats flush, push and pop in the same cycle
        drive(1, 14'h0A01, 0, 0, 0);
        tick();
        drive(1, 14'h0A02, 0, 0, 0);
        tick();
        chk("pre_reset_count", 32'(bus.count), 32'd2);
        reset = 1'b1;
        drive(1, 14'h0555, 1, 1, 1);
        tick();
        reset = 1'b0;
        drive(0, '0, 0, 0, 0);
        idle_chk("mid_reset");
        drive(1, 14'h0123, 0, 0, 0);
        tick();
        drive(0, '0, 0, 0, 0);
        chk("post_reset_instr", 32'(bus.issue_instr), 32'h0123);
        chk("post_reset_count", 32'(bus.count), 32'd1);
        drive(0, '0, 0, 0, 1);
        tick();
        drive(0, '0, 0, 0, 0);
        tick();
        chk("final_count", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction latch.
- Buffers up to DEPTH fetched instructions in a FIFO between the program-memory fetch stage and the decoder, with valid/ready handshakes on both sides.
- Each entry carries a void tag. Voided entries and an empty queue present NOP_VALUE to the decoder.
- A flush input discards all buffered instructions, e.g. on a taken jump.

Parameters:
- INSTR_WIDTH, 14, instruction word width in bits.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- NOP_VALUE, 0, instruction word presented when the head is voided or the queue is empty.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch stage offers an instruction this cycle.
- fetch_instr  in  INSTR_WIDTH  offered instruction word.
- fetch_void  in  1  offered instruction is a bubble; stored with its void tag set.
- fetch_ready  out  1  queue can accept a word; equals not full.
- flush  in  1  discard all entries at this edge.
- issue_ready  in  1  decoder consumes the head this cycle.
- issue_valid  out  1  queue is not empty.
- issue_instr  out  INSTR_WIDTH  head word, or NOP_VALUE (see Behaviour).
- issue_is_void  out  1  head entry's void tag; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (synchronous, active-high):
  - rd_ptr = wr_ptr = 0, count = 0, all void tags cleared.
  - Outputs in the cycle after reset: fetch_ready=1, issue_valid=0, issue_instr=NOP_VALUE, issue_is_void=0, count=0.
  - Reset has priority over flush, push and pop.
- Handshake signals:
  - push = fetch_valid & fetch_ready.
  - pop = issue_ready & issue_valid.
- Push:
  - Writes {fetch_void, fetch_instr} at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping with no bubble.
- Pop:
  - rd_ptr increments modulo DEPTH.
  - A voided head is popped exactly like a normal entry; void tags do not stall.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - Legal only when not full, because fetch_ready=0 when full and no bypass exists.
  - When count=0, pop cannot occur; the pushed word appears next cycle.
- Latency:
  - A word pushed at edge N appears on issue_instr after edge N (one cycle).
  - There is no combinational path from fetch_* to issue_*.
- Output path:
  - issue_instr is combinational from the registered head entry.
  - issue_instr = NOP_VALUE when count=0 or the head void tag is 1; otherwise the stored word.
- Flush:
  - At the edge, rd_ptr <= wr_ptr and count <= 0.
  - Any push or pop in the same cycle is ignored, including the offered fetch word, which the fetch stage re-fetches.
  - Flush while empty is a no-op.
- Full:
  - count=DEPTH gives fetch_ready=0; fetch_valid is ignored.
- Empty:
  - issue_valid=0; issue_ready is ignored.
  - count never underflows and never exceeds DEPTH.
- Storage:
  - The storage array is not reset; only pointers, count and void tags are.
  - Outputs never expose stale storage, because they are gated by count and void tag.
- Control and arithmetic:
  - No FSM. Control consists of rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and count.
  - count is updated as +1 on push only, -1 on pop only, 0 on flush.

Decomposition:
- Shared package holds:
  - the default INSTR_WIDTH (14);
  - the NOP encoding constant;
  - a localparam helper for pointer width.
- One natural sub-module: fifo_mem_dual, a DEPTH x (INSTR_WIDTH+1) register array with synchronous write and combinational read.
- Pointers, count, flush and output gating stay in the top level.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then no stimulus -> count=0, fetch_ready=1, issue_valid=0, issue_instr=0x0000.
- Fill and drain: push 0x1001, 0x1002, 0x1003, 0x1004 with issue_ready=0 -> count=4, fetch_ready=0; a 5th push of 0x1005 is dropped. Then issue_ready=1 for 4 cycles -> issue_instr sequence 0x1001..0x1004, then issue_valid=0.
- Wrap-around: continuous push and pop for 10 words 0x2000..0x2009 with the first pop one cycle after the first push -> count stays 1 and the output order is exact across two pointer wraps.
- Void entry: push 0x3AAA with fetch_void=1, then 0x3BBB -> the first issue shows issue_instr=0x0000 and issue_is_void=1, pops normally; the next issue shows 0x3BBB.
- Flush with simultaneous traffic: 3 entries held; flush=1 in the same cycle as push of 0x3FFF and issue_ready=1 -> next cycle count=0 and issue_valid=0; 0x3FFF never appears at the output.
- Reset mid-operation: 2 entries held; reset=1 in the same cycle as flush, push and pop -> next cycle count=0 with all outputs at their reset values; push 0x0123 afterwards -> it issues first.
